// File: rtl/am_regmux.sv
// am_regmux: registered N-channel multiplexer with optional auto-scan.
//
// Selects one of CHANNELS input words, either from the external select s
// (manual mode) or from an internal scan counter (scan mode). The chosen word
// is captured in an output register. y exposes that register through an
// active-low output gate.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high; clears all state
//   d       packed channel words, channel k at d[k*WIDTH +: WIDTH]
//   s       external select, or the scan preset when ld_sel=1
//   en_     active-low clock enable; 1 holds yreg/ch/cnt and clears wrap
//   scan    0 = manual select by s, 1 = auto-scan by the internal counter
//   ld_sel  scan mode only: use s this cycle and re-seed the counter from it
//   oe_     active-low output gate; 1 forces y to zero (combinational)
//   y       gated registered channel word
//   ch      index of the channel held in the output register
//   wrap    registered pulse: last capture was channel CHANNELS-1 in scan mode
module am_regmux #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 2,
  localparam int SELW     = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*CHANNELS-1:0] d,
  input  logic [SELW-1:0]           s,
  input  logic                      en_,
  input  logic                      scan,
  input  logic                      ld_sel,
  input  logic                      oe_,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      wrap
);

  // One extra bit so CHANNELS itself is representable when it is a power of two.
  localparam logic [SELW:0] NUM_CH  = CHANNELS[SELW:0];
  localparam logic [SELW:0] LAST_CH = NUM_CH - {{SELW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] yreg_q, yreg_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [SELW-1:0]  cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  logic [SELW-1:0]  sel_s;
  logic             in_range_s;
  logic             is_last_s;
  logic [WIDTH-1:0] word_s;

  // Effective select and the word it addresses.
  always_comb begin
    sel_s      = s;
    in_range_s = 1'b0;
    is_last_s  = 1'b0;
    word_s     = {WIDTH{1'b0}};
    if (scan && !ld_sel) begin
      sel_s = cnt_q;
    end else begin
      sel_s = s;
    end
    in_range_s = ({1'b0, sel_s} < NUM_CH);
    is_last_s  = ({1'b0, sel_s} == LAST_CH);
    // Unused select codes (non power-of-two CHANNELS) capture zero.
    if (in_range_s) begin
      word_s = d[sel_s*WIDTH +: WIDTH];
    end else begin
      word_s = {WIDTH{1'b0}};
    end
  end

  // Next-state computation for the capture register, channel index, counter and wrap.
  always_comb begin
    yreg_d = yreg_q;
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (en_) begin
      // Disabled: hold captured state, wrap is a one-cycle pulse so it drops.
      yreg_d = yreg_q;
      ch_d   = ch_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
    end else begin
      yreg_d = word_s;
      ch_d   = sel_s;
      if (scan) begin
        // The counter is only ever written with 0 or an in-range sel+1.
        if (is_last_s || !in_range_s) begin
          cnt_d = {SELW{1'b0}};
        end else begin
          cnt_d = sel_s + SELW'(1'b1);
        end
        wrap_d = is_last_s;
      end else begin
        // Manual mode freezes the counter so scanning can resume later.
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      yreg_q <= {WIDTH{1'b0}};
      ch_q   <= {SELW{1'b0}};
      cnt_q  <= {SELW{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      yreg_q <= yreg_d;
      ch_q   <= ch_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // Output gate is combinational on purpose: oe_ acts with zero latency.
  assign y    = oe_ ? {WIDTH{1'b0}} : yreg_q;
  assign ch   = ch_q;
  assign wrap = wrap_q;

endmodule
